// File: rtl/eth_tx_buf_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_buf_wr_ctrl_if
// Brief    : Stream, buffer port B, descriptor and release bundle of the TX
//            buffer write controller.
// Revision : 1.0 - initial release
// ============================================================================
interface eth_tx_buf_wr_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic [31:0]       s_tdata;
    logic [3:0]        s_tkeep;
    logic              s_tvalid;
    logic              s_tlast;
    logic              s_tready;
    logic              weB;
    logic              enaB;
    logic [ADDR_W-1:0] addrB;
    logic [31:0]       diB;
    logic              desc_valid;
    logic              desc_ready;
    logic [ADDR_W+1:0] desc_start;
    logic [11:0]       desc_len;
    logic              rel_valid;
    logic [ADDR_W:0]   rel_words;
    logic [ADDR_W:0]   free_words;
    logic [15:0]       drop_cnt;

    // The controller is the stream sink and the buffer/descriptor source.
    modport slave (
        input  s_tdata, s_tkeep, s_tvalid, s_tlast, desc_ready, rel_valid, rel_words,
        output s_tready, weB, enaB, addrB, diB, desc_valid, desc_start, desc_len,
               free_words, drop_cnt
    );

    modport master (
        output s_tdata, s_tkeep, s_tvalid, s_tlast, desc_ready, rel_valid, rel_words,
        input  s_tready, weB, enaB, addrB, diB, desc_valid, desc_start, desc_len,
               free_words, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/eth_tx_buf_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_buf_wr_ctrl
// Brief    : Writes AXI-Stream frames into the TX buffer and commits one
//            descriptor per complete frame; drops frames that do not fit.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_buf_wr_ctrl #(
    parameter int DEPTH_W    = 512,
    parameter int ADDR_W     = 9,
    parameter int DESC_DEPTH = 4,
    parameter int MAX_BYTES  = 1536
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eth_tx_buf_wr_ctrl_if.slave  bus
);
    localparam int              c_DAW   = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH_W);
    localparam logic [11:0]     c_MAX   = 12'(MAX_BYTES);
    localparam logic [c_DAW:0]  c_DFULL = (c_DAW+1)'(DESC_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STORE  = 2'd1,
        S_DROP   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t            r_state, w_stateNext;
    logic              r_tready, r_we;
    logic [ADDR_W-1:0] r_addr, r_wrPtr, r_commitPtr, r_startPtr;
    logic [31:0]       r_di;
    logic [11:0]       r_byteCnt;
    logic [ADDR_W:0]   r_wordCnt, r_used, r_free;
    logic [15:0]       r_dropCnt;
    logic [ADDR_W+1:0] r_descStart [DESC_DEPTH];
    logic [11:0]       r_descLen   [DESC_DEPTH];
    logic [c_DAW-1:0]  r_descWr, r_descRd;
    logic [c_DAW:0]    r_descCount, w_descCountNext;

    logic              w_fire, w_inFrame, w_full, w_over, w_drop, w_write, w_push, w_pop;
    logic [2:0]        w_keepCnt;
    logic [11:0]       w_bytesNext;
    logic [ADDR_W:0]   w_wordsBase, w_commitWords, w_usedNext;
    logic [ADDR_W+1:0] w_usedSum, w_relWords;

    always_comb begin
        w_fire      = bus.s_tvalid & r_tready;
        w_inFrame   = (r_state == S_IDLE) || (r_state == S_STORE);
        w_keepCnt   = 3'(bus.s_tkeep[0]) + 3'(bus.s_tkeep[1])
                    + 3'(bus.s_tkeep[2]) + 3'(bus.s_tkeep[3]);
        w_bytesNext = ((r_state == S_IDLE) ? 12'd0 : r_byteCnt) + 12'(w_keepCnt);
        w_wordsBase = (r_state == S_IDLE) ? '0 : r_wordCnt;
        // A data-less beat (zero-length frame) needs no buffer space.
        w_full      = (w_keepCnt != 3'd0) && (w_wordsBase == (c_DEPTH - r_used));
        w_over      = w_bytesNext > c_MAX;
        w_drop      = w_fire && w_inFrame && (w_full || w_over);
        w_write     = w_fire && w_inFrame && !w_drop && (w_keepCnt != 3'd0);
        w_push      = (r_state == S_COMMIT);
        w_pop       = (r_descCount != '0) && bus.desc_ready;
        w_descCountNext = r_descCount + (c_DAW+1)'(w_push) - (c_DAW+1)'(w_pop);
        w_commitWords   = (ADDR_W+1)'((r_byteCnt + 12'd3) >> 2);
        w_usedSum   = {1'b0, r_used} + (w_push ? {1'b0, w_commitWords} : '0);
        w_relWords  = bus.rel_valid ? {1'b0, bus.rel_words} : '0;
        w_usedNext  = (w_relWords > w_usedSum) ? '0 : (ADDR_W+1)'(w_usedSum - w_relWords);

        w_stateNext = r_state;
        case (r_state)
            S_IDLE, S_STORE: begin
                if (w_fire) begin
                    if (w_drop)
                        w_stateNext = bus.s_tlast ? S_IDLE : S_DROP;
                    else if (bus.s_tlast)
                        w_stateNext = S_COMMIT;
                    else
                        w_stateNext = S_STORE;
                end
            end
            S_DROP:   if (w_fire && bus.s_tlast) w_stateNext = S_IDLE;
            S_COMMIT: w_stateNext = S_IDLE;
            default:  w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tready    <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_di        <= '0;
            r_wrPtr     <= '0;
            r_commitPtr <= '0;
            r_startPtr  <= '0;
            r_byteCnt   <= '0;
            r_wordCnt   <= '0;
            r_used      <= '0;
            r_free      <= c_DEPTH;
            r_dropCnt   <= '0;
            r_descWr    <= '0;
            r_descRd    <= '0;
            r_descCount <= '0;
        end else begin
            r_state  <= w_stateNext;
            // Ready is precomputed from the next state so it can be a flop.
            r_tready <= (w_stateNext == S_IDLE) ? (w_descCountNext != c_DFULL)
                                                : (w_stateNext != S_COMMIT);
            r_we     <= w_write;
            if (w_write) begin
                r_addr  <= r_wrPtr;
                r_di    <= bus.s_tdata;
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_fire && w_inFrame) begin
                r_byteCnt <= w_bytesNext;
                r_wordCnt <= w_wordsBase + (ADDR_W+1)'(w_write);
            end
            if (w_fire && (r_state == S_IDLE))
                r_startPtr <= r_commitPtr;
            if (w_drop) begin
                r_wrPtr <= r_commitPtr;
                if (r_dropCnt != 16'hFFFF)
                    r_dropCnt <= r_dropCnt + 16'd1;
            end
            if (w_push) begin
                r_commitPtr <= r_wrPtr;
                r_descWr    <= r_descWr + 1'b1;
            end
            if (w_pop)
                r_descRd <= r_descRd + 1'b1;
            r_descCount <= w_descCountNext;
            r_used      <= w_usedNext;
            r_free      <= c_DEPTH - w_usedNext;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_descStart[r_descWr] <= {r_startPtr, 2'b00};
            r_descLen[r_descWr]   <= r_byteCnt;
        end
    end

    assign bus.s_tready   = r_tready;
    assign bus.weB        = r_we;
    assign bus.enaB       = r_we;
    assign bus.addrB      = r_addr;
    assign bus.diB        = r_di;
    assign bus.desc_valid = (r_descCount != '0);
    assign bus.desc_start = r_descStart[r_descRd];
    assign bus.desc_len   = r_descLen[r_descRd];
    assign bus.free_words = r_free;
    assign bus.drop_cnt   = r_dropCnt;
endmodule
`default_nettype wire

// File: tb/tb_eth_tx_buf_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_buf_wr_ctrl
// Brief    : Frame-level reference model bench for eth_tx_buf_wr_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_buf_wr_ctrl;
    localparam int c_DEPTH = 512;
    localparam int c_AW    = 9;
    localparam int c_DD    = 4;
    localparam int c_MAX   = 1536;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_tx_buf_wr_ctrl_if #(.ADDR_W(c_AW)) bus();

    eth_tx_buf_wr_ctrl #(
        .DEPTH_W(c_DEPTH), .ADDR_W(c_AW), .DESC_DEPTH(c_DD), .MAX_BYTES(c_MAX)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int nChecks = 0;
    int nPass   = 0;
    // Frame-level model: committed words, next frame start, drops, descriptors.
    int mUsed, mCommit, mDrops;
    int qStart[$];
    int qLen[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic step(input bit expWe, input int expAddr, input logic [31:0] expData);
        @(posedge clk);
        @(negedge clk);
        check("weB", 32'(bus.weB), 32'(expWe));
        if (expWe) begin
            check("enaB", 32'(bus.enaB), 32'd1);
            check("addrB", 32'(bus.addrB), 32'(expAddr));
            check("diB", bus.diB, expData);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, '0);
    endtask

    task automatic check_reset_vals();
        check("rst_tready", 32'(bus.s_tready), 32'd0);
        check("rst_weB", 32'(bus.weB), 32'd0);
        check("rst_enaB", 32'(bus.enaB), 32'd0);
        check("rst_addrB", 32'(bus.addrB), 32'd0);
        check("rst_diB", bus.diB, 32'd0);
        check("rst_desc_valid", 32'(bus.desc_valid), 32'd0);
        check("rst_free", 32'(bus.free_words), 32'(c_DEPTH));
        check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    endtask

    task automatic model_reset();
        mUsed = 0; mCommit = 0; mDrops = 0;
        qStart.delete(); qLen.delete();
    endtask

    task automatic drive_beat(input logic [31:0] data, input int nb, input bit last,
                              input bit wr, input int addr, output int waited);
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = data;
        bus.s_tkeep  = 4'((1 << nb) - 1);
        bus.s_tlast  = last;
        waited = 0;
        while (!bus.s_tready && waited < 64) begin
            step(1'b0, 0, '0);
            waited++;
        end
        if (!bus.s_tready) check("tready_timeout", 32'(bus.s_tready), 32'd1);
        else step(wr, addr, data);
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic pop_desc();
        if (qLen.size() == 0) return;
        check("pop_valid", 32'(bus.desc_valid), 32'd1);
        check("desc_start", 32'(bus.desc_start), 32'(qStart[0]));
        check("desc_len", 32'(bus.desc_len), 32'(qLen[0]));
        bus.desc_ready = 1'b1;
        step(1'b0, 0, '0);
        bus.desc_ready = 1'b0;
        void'(qStart.pop_front());
        void'(qLen.pop_front());
    endtask

    task automatic rel(input int n);
        bus.rel_valid = 1'b1;
        bus.rel_words = 10'(n);
        step(1'b0, 0, '0);
        bus.rel_valid = 1'b0;
        mUsed = (mUsed > n) ? mUsed - n : 0;
    endtask

    task automatic send_frame(input int nBytes, input bit relOnCommit, input int relWords);
        int beats, words, freeW, dropIdx, cum, nb, start, waited;
        beats   = (nBytes == 0) ? 1 : (nBytes + 3) / 4;
        words   = (nBytes + 3) / 4;
        freeW   = c_DEPTH - mUsed;
        start   = mCommit;
        dropIdx = -1;
        cum     = 0;
        // The frame dies on the first data beat with no room, or the first beat past MAX.
        for (int i = 0; i < beats; i++) begin
            nb = (i < beats - 1) ? 4 : nBytes - 4 * (beats - 1);
            cum += nb;
            if (dropIdx < 0 && ((nb > 0 && i == freeW) || cum > c_MAX)) dropIdx = i;
        end
        for (int i = 0; i < beats; i++) begin
            nb = (i < beats - 1) ? 4 : nBytes - 4 * (beats - 1);
            drive_beat($urandom, nb, i == beats - 1, (dropIdx < 0 || i < dropIdx) && nb > 0,
                       (start + i) % c_DEPTH, waited);
            if (dropIdx >= 0 && i > dropIdx) check("drop_wait", 32'(waited), 32'd0);
        end
        if (dropIdx < 0) begin
            check("tready_commit", 32'(bus.s_tready), 32'd0);
            if (relOnCommit && qLen.size() > 0) begin
                check("commit_pop_start", 32'(bus.desc_start), 32'(qStart[0]));
                check("commit_pop_len", 32'(bus.desc_len), 32'(qLen[0]));
                bus.desc_ready = 1'b1;
                bus.rel_valid  = 1'b1;
                bus.rel_words  = 10'(relWords);
                void'(qStart.pop_front());
                void'(qLen.pop_front());
                mUsed = (mUsed + words > relWords) ? mUsed + words - relWords : 0;
            end else begin
                mUsed += words;
            end
            step(1'b0, 0, '0);
            bus.desc_ready = 1'b0;
            bus.rel_valid  = 1'b0;
            check("desc_valid_post", 32'(bus.desc_valid), 32'd1);
            qStart.push_back(start * 4);
            qLen.push_back(nBytes);
            mCommit = (start + words) % c_DEPTH;
        end else if (mDrops < 16'hFFFF) begin
            mDrops++;
        end
        idle(2);
        check("free_words", 32'(bus.free_words), 32'(c_DEPTH - mUsed));
        check("drop_cnt", 32'(bus.drop_cnt), 32'(mDrops));
        check("desc_valid", 32'(bus.desc_valid), 32'(qLen.size() > 0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int w, waited;
        bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.s_tkeep = '0; bus.s_tlast = 1'b0;
        bus.desc_ready = 1'b0; bus.rel_valid = 1'b0; bus.rel_words = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        model_reset();
        idle(1);

        // 64-byte frame, then a 10-byte frame followed by a second frame
        send_frame(64, 1'b0, 0);
        pop_desc();
        rel(16);
        send_frame(10, 1'b0, 0);
        send_frame(20, 1'b0, 0);
        pop_desc(); pop_desc();
        rel(8);

        // Advance the commit pointer to 508 and wrap an 8-beat frame
        while (mCommit != 508) begin
            w = (508 - mCommit + c_DEPTH) % c_DEPTH;
            if (w > 384) w = 384;
            send_frame(w * 4, 1'b0, 0);
            pop_desc();
            rel(w);
        end
        send_frame(32, 1'b0, 0);
        check("wrap_start", 32'(bus.desc_start), 32'd2032);
        pop_desc();
        rel(8);

        // Fill to 4 free words, overflow a 6-beat frame, then commit 4 beats
        while (mUsed < 508) begin
            w = 508 - mUsed;
            if (w > 384) w = 384;
            send_frame(w * 4, 1'b0, 0);
            pop_desc();
        end
        send_frame(24, 1'b0, 0);
        send_frame(16, 1'b0, 0);
        pop_desc();
        rel(c_DEPTH);

        // Oversize frames and the exact maximum
        send_frame(1540, 1'b0, 0);
        send_frame(1700, 1'b0, 0);
        send_frame(c_MAX, 1'b0, 0);
        pop_desc();
        rel(c_DEPTH);

        // Zero-length frame
        send_frame(0, 1'b0, 0);
        pop_desc();

        // Full descriptor FIFO holds off IDLE; pop + release in a COMMIT cycle
        for (int i = 0; i < c_DD; i++) send_frame(16, 1'b0, 0);
        bus.s_tvalid = 1'b1; bus.s_tkeep = 4'hF; bus.s_tdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, '0);
            check("tready_full", 32'(bus.s_tready), 32'd0);
        end
        bus.s_tvalid = 1'b0;
        pop_desc();
        send_frame(64, 1'b1, 16);
        while (qLen.size() > 0) pop_desc();
        rel(c_DEPTH);

        // Randomised traffic
        for (int k = 0; k < 30; k++) begin
            int n;
            while (qLen.size() >= c_DD) pop_desc();
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(0, 16);
                1:       n = $urandom_range(1500, 1700);
                default: n = $urandom_range(17, 1499);
            endcase
            send_frame(n, (qLen.size() > 0) && ($urandom_range(0, 3) == 0), $urandom_range(0, 64));
            if ($urandom_range(0, 1) == 1) pop_desc();
            rel($urandom_range(0, mUsed + 8));
        end

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++)
            drive_beat($urandom, 4, 1'b0, 1'b1, (mCommit + i) % c_DEPTH, waited);
        rst_n = 1'b0;
        step(1'b0, 0, '0);
        check_reset_vals();
        rst_n = 1'b1;
        model_reset();
        send_frame(16, 1'b0, 0);
        pop_desc();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/eth_tx_buf_wr_ctrl.md
Name: eth_tx_buf_wr_ctrl

Overview:
- Write-side controller for the 512x32 dual-port TX frame buffer.
- Accepts 32-bit AXI-Stream frames and writes them as words through buffer port B.
- Tracks buffer occupancy and commits one descriptor (start byte address, byte length) per complete frame to a small descriptor FIFO, which the MAC-side reader consumes.
- Drops frames that do not fit or are oversize; a dropped frame never becomes visible to the reader.

Parameters:
- DEPTH_W, 512, buffer depth in 32-bit words (power of 2).
- ADDR_W, 9, log2(DEPTH_W); byte address width is ADDR_W+2.
- DESC_DEPTH, 4, descriptor FIFO entries (power of 2).
- MAX_BYTES, 1536, largest accepted frame in bytes.

Ports:
- clk  in  1  single clock; also drives buffer port B.
- rst_n  in  1  synchronous, active-low reset.
- s_tdata  in  32  frame data, byte 0 in [7:0].
- s_tkeep  in  4  byte enables, low-aligned, all-ones except on the tlast beat.
- s_tvalid  in  1  upstream valid.
- s_tlast  in  1  last beat of frame.
- s_tready  out  1  accept.
- weB  out  1  buffer write enable.
- enaB  out  1  buffer port enable.
- addrB  out  ADDR_W  buffer word address.
- diB  out  32  buffer write data.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  reader pops descriptor.
- desc_start  out  ADDR_W+2  frame start byte address (word-aligned).
- desc_len  out  12  frame length in bytes.
- rel_valid  in  1  reader releases words of a finished frame.
- rel_words  in  ADDR_W+1  words released.
- free_words  out  ADDR_W+1  DEPTH_W minus committed words.
- drop_cnt  out  16  dropped frames, saturating.

Behaviour:
- Reset values: s_tready=0, weB=0, enaB=0, addrB=0, diB=0, desc_valid=0, free_words=DEPTH_W, drop_cnt=0. Write pointer, commit pointer and used count are 0. FIFO is empty. FSM is in IDLE.
- FSM has four states: IDLE, STORE, DROP, COMMIT.
- IDLE:
  - s_tready = (descriptor FIFO not full).
  - A beat accepted here is the first beat of a frame. Latch start = commit pointer, then handle it as a STORE beat.
- STORE:
  - s_tready=1.
  - Each accepted beat is registered. In the next cycle, weB=enaB=1, addrB=wr_ptr, diB=s_tdata. The SRAM write latency is therefore 1 cycle after acceptance.
  - wr_ptr increments modulo DEPTH_W and wraps 511->0.
  - Byte count accumulates popcount(s_tkeep).
- Drop conditions (checked per beat, before writing):
  - The word count of the frame in progress already equals DEPTH_W-used, i.e. the buffer is full.
  - The byte count would exceed MAX_BYTES.
  - On a drop, the beat is not written, wr_ptr rewinds to the commit pointer, and drop_cnt increments (saturating at 0xFFFF).
  - If the beat also has tlast, go to IDLE; otherwise go to DROP.
- DROP: s_tready=1 and no writes. Go to IDLE on the accepted tlast beat.
- Accepted tlast in STORE without a drop condition: go to COMMIT.
- COMMIT (1 cycle):
  - s_tready=0.
  - Push {start*4, byte_count} into the FIFO.
  - Commit pointer = wr_ptr.
  - used += ceil(byte_count/4).
  - Return to IDLE.
  - desc_valid asserts the cycle after COMMIT if the FIFO was empty.
- Descriptor FIFO:
  - FWD outputs, i.e. the head is visible on desc_start/desc_len.
  - desc_valid=1 while non-empty; pop on desc_valid&desc_ready.
  - A push and a pop in the same cycle are both honoured.
- Release:
  - rel_valid subtracts rel_words from used in the same cycle that a commit adds; the net effect is applied.
  - If rel_words exceeds used, used clamps to 0.
  - free_words is registered and updates the cycle after a change.
- Zero-length frame (single beat with tkeep=0, tlast=1):
  - No write is issued.
  - A descriptor with len=0 is pushed, and used is unchanged.
- Reset asserted mid-frame: all state returns to reset values. A partial frame is discarded without counting a drop.

Test Plan:
- Single 64-byte frame (16 beats, tkeep=F) -> 16 writes at addrB 0..15, each 1 cycle after acceptance; desc_start=0, desc_len=64; free_words=496.
- Frame of 10 bytes (beats with tkeep F, F, 3) -> 3 writes; desc_len=10; used=3. A second frame -> desc_start=12.
- Start frames at wr_ptr=508 with 8 beats -> addrB sequence 508..511, 0..3; desc_start=2032; wrap is correct.
- Fill the buffer to free_words=4, then send a 6-beat frame -> beats 5-6 discarded, drop_cnt=1, no descriptor, wr_ptr restored. The next 4-beat frame commits at the original start.
- 1540-byte frame -> dropped, drop_cnt increments, remainder consumed with s_tready=1.
- Hold desc_ready=0 with DESC_DEPTH frames committed -> s_tready=0 in IDLE. A pop plus rel_valid (rel_words=16) in the COMMIT cycle -> used is net-adjusted and traffic resumes.
